soc_bus_router: RTL and testbench

//  Single-outstanding request router between the CPU data port and the SoC slaves (mem, gpio, uart).

---
 rtl/soc_bus_pkg.sv | 19 +
 rtl/soc_bus_watchdog.sv | 34 +++
 rtl/soc_bus_router.sv | 179 +++++++++++++++++
 tb/tb_soc_bus_router.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus router: FSM states, slave indices,
// and the read data returned with error responses.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  localparam int SLV_MEM  = 0;
  localparam int SLV_GPIO = 1;
  localparam int SLV_UART = 2;
  localparam int NSLV     = 3;

  localparam int ERR_RDATA = 0;

endpackage

// File: rtl/soc_bus_watchdog.sv
// Transaction watchdog: 16-bit cycle counter with an expiry compare against
// TIMEOUT_CYCLES-1. Only instantiated when SOC_BUS_TIMEOUT_EN is defined.
module soc_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/soc_bus_router.sv
// Single-outstanding CPU-to-slave request router with registered response.
// Define SOC_BUS_TIMEOUT_EN to add the hung-slave watchdog (soc_bus_watchdog).
module soc_bus_router #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int NSLV           = soc_bus_pkg::NSLV,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic               req_we,
  input  logic [DW-1:0]      req_wdata,
  input  logic [DW/8-1:0]    req_wstrb,
  input  logic [NSLV-1:0]    sel_in,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    s_valid,
  input  logic [NSLV-1:0]    s_ready,
  output logic [AW-1:0]      s_addr,
  output logic               s_we,
  output logic [DW-1:0]      s_wdata,
  output logic [DW/8-1:0]    s_wstrb,
  input  logic [NSLV-1:0]    s_rvalid,
  input  logic [NSLV*DW-1:0] s_rdata
);
  import soc_bus_pkg::*;

  localparam int SW = DW / 8;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("soc_bus_router: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t          state_q, state_d;
  logic [NSLV-1:0] oh_q, oh_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [NSLV-1:0] sel_low;
  logic [DW-1:0]   slv_rdata;
  logic            slv_ready;
  logic            slv_rvalid;
  logic            expired;

  // Isolate the lowest set select bit so the lowest slave index wins.
  assign sel_low    = sel_in & (~sel_in + NSLV'(1));
  assign slv_ready  = |(s_ready & oh_q);
  assign slv_rvalid = |(s_rvalid & oh_q);

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (oh_q[i]) begin
        slv_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

`ifdef SOC_BUS_TIMEOUT_EN
  logic wd_clr;
  logic wd_run;

  assign wd_clr = (state_q == ST_IDLE) && (state_d == ST_REQ);
  assign wd_run = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);

  soc_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .run    (wd_run),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    oh_d    = oh_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          oh_d    = sel_low;
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (|sel_in) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = DW'(ERR_RDATA);
          end
        end
      end
      ST_REQ: begin
        // A completion in the expiry cycle takes priority over the timeout.
        if (slv_ready && slv_rvalid) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : slv_rdata;
        end else if (expired) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = DW'(ERR_RDATA);
        end else if (slv_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (slv_rvalid) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : slv_rdata;
        end else if (expired) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = DW'(ERR_RDATA);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      oh_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  assign s_valid   = (state_q == ST_REQ) ? oh_q : '0;
  assign s_addr    = addr_q;
  assign s_we      = we_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;

endmodule

// File: tb/tb_soc_bus_router.sv
// Scoreboard bench for soc_bus_router: expected responses are queued at accept
// and compared (data, error, cycle) when rsp_valid fires.
`timescale 1ns/1ps
module tb_soc_bus_router;
  import soc_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_addr;
  logic               req_we;
  logic [DW-1:0]      req_wdata;
  logic [SW-1:0]      req_wstrb;
  logic [NSLV-1:0]    sel_in;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [NSLV-1:0]    s_valid;
  logic [NSLV-1:0]    s_ready;
  logic [AW-1:0]      s_addr;
  logic               s_we;
  logic [DW-1:0]      s_wdata;
  logic [SW-1:0]      s_wstrb;
  logic [NSLV-1:0]    s_rvalid;
  logic [NSLV*DW-1:0] s_rdata;

  soc_bus_router #(
    .AW(AW), .DW(DW), .NSLV(NSLV), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .sel_in(sel_in),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_we(s_we),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  typedef struct {
    int rdy;
    int rsp;
    bit hang;
  } scfg_t;

  exp_t  exp_q[$];
  scfg_t cfg_q[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    n_rsp = 0;
  int    cyc = 0;

  logic [DW-1:0]   slv_data [NSLV];
  logic [NSLV-1:0] force_rvalid = '0;

  int              win_lo = -1, win_hi = -2;
  int              busy_lo = -1, busy_hi = -2;
  logic [NSLV-1:0] win_oh = '0;
  logic [AW-1:0]   win_addr = '0;
  logic [DW-1:0]   win_wdata = '0;
  logic [SW-1:0]   win_wstrb = '0;
  logic            win_we = 1'b0;

  assign s_rdata = {slv_data[SLV_UART], slv_data[SLV_GPIO], slv_data[SLV_MEM]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave model: per-transaction config popped on first s_valid; non-selected
  // slaves toggle ready/rvalid randomly and must be ignored.
  initial begin : slave_model
    int              phase;
    int              wcnt;
    int              rcnt;
    bit              have;
    scfg_t           cur;
    logic [NSLV-1:0] cur_sel;
    logic [NSLV-1:0] mask;
    phase = 0; wcnt = 0; rcnt = 0; have = 0; cur_sel = '0;
    cur = '{0, 0, 1'b0};
    s_ready = '0;
    s_rvalid = '0;
    forever begin
      @(negedge clk);
      s_ready = '0;
      s_rvalid = '0;
      if (!rst_n || rsp_valid) begin
        phase = 0; have = 0; wcnt = 0;
      end else if (phase == 0 && |s_valid) begin
        if (!have) begin
          if (cfg_q.size() != 0) cur = cfg_q.pop_front();
          else cur = '{0, 0, 1'b0};
          have = 1; wcnt = 0;
        end
        cur_sel = s_valid;
        if (wcnt == cur.rdy) begin
          s_ready = s_valid;
          if (cur.rsp == 0 && !cur.hang) s_rvalid = s_valid;
          else begin phase = 1; rcnt = 0; end
          have = 0;
        end else begin
          wcnt++;
        end
      end else if (phase == 1) begin
        rcnt++;
        if (rcnt == cur.rsp && !cur.hang) begin
          s_rvalid = cur_sel;
          phase = 0;
        end
      end
      mask = (|s_valid) ? s_valid : cur_sel;
      s_ready  = s_ready  | (~mask & NSLV'($urandom));
      s_rvalid = s_rvalid | (~mask & NSLV'($urandom)) | force_rvalid;
    end
  end

  initial begin : monitor
    logic [NSLV-1:0] esv;
    exp_t            e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        esv = (cyc >= win_lo && cyc <= win_hi) ? win_oh : '0;
        chk("s_valid", 64'(s_valid), 64'(esv));
        if (esv != '0) begin
          chk("s_addr", 64'(s_addr), 64'(win_addr));
          chk("s_wdata", 64'(s_wdata), 64'(win_wdata));
          chk("s_wstrb", 64'(s_wstrb), 64'(win_wstrb));
          chk("s_we", 64'(s_we), 64'(win_we));
        end
        chk("req_ready", 64'(req_ready), (cyc >= busy_lo && cyc <= busy_hi) ? 64'd0 : 64'd1);
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            n_rsp++;
            chk("rsp_cycle", 64'(cyc), 64'(e.due));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            $display("rsp %0d: rdata=%08h err=%0d cycle=%0d", n_rsp, rsp_rdata, rsp_err, cyc);
          end
        end
      end
    end
  end

  task automatic do_req(input logic [AW-1:0] addr, input bit we, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [NSLV-1:0] sel,
                        input int rdy, input int rsp, input bit hang, input bit hold);
    int    guard;
    int    idx;
    int    acc;
    int    lat;
    exp_t  e;
    scfg_t c;
    guard = 0;
    idx = -1;
    req_valid = 1'b1; req_addr = addr; req_we = we;
    req_wdata = wd; req_wstrb = ws; sel_in = sel;
    while (!req_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    for (int i = NSLV - 1; i >= 0; i--) if (sel[i]) idx = i;
    if (idx < 0) begin
      lat = 0; e.rdata = '0; e.err = 1'b1;
    end else begin
      if (hang) begin
        lat = TO; e.rdata = '0; e.err = 1'b1;
      end else begin
        lat = rdy + 1 + rsp; e.err = 1'b0;
        e.rdata = we ? '0 : slv_data[idx];
      end
      c = '{rdy, rsp, hang};
      cfg_q.push_back(c);
      win_lo = acc; win_hi = acc + rdy; win_oh = NSLV'(1) << idx;
      win_addr = addr; win_wdata = wd; win_wstrb = ws; win_we = we;
    end
    e.due = acc + lat;
    exp_q.push_back(e);
    busy_lo = acc; busy_hi = acc + lat;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish (vectors %0d)", n_vec);
    $fatal(1, "global timeout");
  end

  initial begin : main
    logic [NSLV-1:0] rsel;
    slv_data[SLV_MEM]  = 32'h1234_5678;
    slv_data[SLV_GPIO] = 32'h0000_00C3;
    slv_data[SLV_UART] = 32'h0000_0055;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; req_wstrb = '0; sel_in = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait mem read, then gpio write with wait states, then unmapped.
    do_req(32'h0000_0010, 1'b0, '0, 4'h0, 3'b001, 0, 0, 1'b0, 1'b0);
    wait_idle();
    do_req(32'h4000_0000, 1'b1, 32'h0000_00A5, 4'hF, 3'b010, 2, 2, 1'b0, 1'b0);
    wait_idle();
    do_req(32'h7000_0000, 1'b0, '0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);
    wait_idle();

    // Late response while idle must be ignored.
    force_rvalid = 3'b111;
    repeat (2) @(negedge clk);
    force_rvalid = '0;

    // Completion in the cycle the watchdog would expire still succeeds.
    do_req(32'h5000_0004, 1'b0, '0, 4'h0, 3'b100, 0, TO - 1, 1'b0, 1'b0);
    wait_idle();

`ifdef SOC_BUS_TIMEOUT_EN
    do_req(32'h5000_0000, 1'b0, '0, 4'h0, 3'b100, 0, 0, 1'b1, 1'b0);
    wait_idle();
    force_rvalid = 3'b100;
    repeat (2) @(negedge clk);
    force_rvalid = '0;
    do_req(32'h5000_0000, 1'b0, '0, 4'h0, 3'b100, 1, 1, 1'b0, 1'b0);
    wait_idle();
`endif

    // Reset while waiting for the slave response.
    do_req(32'h4000_0008, 1'b1, 32'hDEAD_BEEF, 4'h3, 3'b010, 0, 6, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_s_valid", 64'(s_valid), 64'd0);
    chk("arst_s_addr", 64'(s_addr), 64'd0);
    chk("arst_s_wdata", 64'(s_wdata), 64'd0);
    chk("arst_s_we", 64'(s_we), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete(); cfg_q.delete();
    win_lo = -1; win_hi = -2; busy_lo = -1; busy_hi = -2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Back-to-back with req_valid held high, including multi-select priority.
    do_req(32'h0000_0100, 1'b0, '0, 4'h0, 3'b111, 0, 0, 1'b0, 1'b1);
    do_req(32'h4000_0010, 1'b0, '0, 4'h0, 3'b110, 1, 0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      rsel = NSLV'($urandom_range(0, 7));
      do_req($urandom, 1'($urandom), $urandom, SW'($urandom), rsel,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, k != 9);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
